// File: rtl/imem_fetch_responder.sv
// Instruction-fetch memory responder: word storage with a load port, a one-entry
// line buffer for repeat fetches, and a configurable wait-state delay on buffer misses.
module imem_fetch_responder #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              read_req,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_data,
    output logic              data_ready,
    output logic              busy,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);

    // state   | meaning
    // ST_IDLE | no transaction
    // ST_WAIT | miss pending, wait counter running
    // ST_RESP | data_ready high for the accepted request
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int         DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_nx;
    logic [ADDR_W-1:0] lat_addr, lat_addr_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              buf_valid, buf_valid_nx;
    logic [ADDR_W-1:0] buf_addr, buf_addr_nx;
    logic [DATA_W-1:0] buf_data, buf_data_nx;
    logic [DATA_W-1:0] read_data_nx;
    logic              data_ready_nx;
    logic              busy_nx;

    logic              accept;
    logic              hit;
    logic              fill;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;

    assign accept = read_req && (state != ST_WAIT);
    assign hit    = accept && buf_valid && (read_addr == buf_addr);

    always_comb begin
        state_nx      = state;
        lat_addr_nx   = lat_addr;
        cnt_nx        = cnt;
        buf_valid_nx  = buf_valid;
        buf_addr_nx   = buf_addr;
        buf_data_nx   = buf_data;
        read_data_nx  = read_data;
        data_ready_nx = data_ready;
        fill          = 1'b0;
        fill_addr     = read_addr;
        fill_data     = '0;

        case (state)
            ST_WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    fill      = 1'b1;
                    fill_addr = lat_addr;
                end
            end
            default: begin
                if (hit) begin
                    read_data_nx  = buf_data;
                    data_ready_nx = 1'b1;
                    state_nx      = ST_RESP;
                end else if (accept) begin
                    if (WAIT_STATES == 0) begin
                        fill      = 1'b1;
                        fill_addr = read_addr;
                    end else begin
                        lat_addr_nx   = read_addr;
                        cnt_nx        = WS;
                        data_ready_nx = 1'b0;
                        state_nx      = ST_WAIT;
                    end
                end else begin
                    data_ready_nx = 1'b0;
                    state_nx      = ST_IDLE;
                end
            end
        endcase

        // Memory read happens before this edge's load lands, so a colliding
        // load is not seen by the completing fetch.
        if (fill) begin
            fill_data     = mem[fill_addr];
            read_data_nx  = fill_data;
            data_ready_nx = 1'b1;
            state_nx      = ST_RESP;
            buf_valid_nx  = 1'b1;
            buf_addr_nx   = fill_addr;
            buf_data_nx   = fill_data;
        end

        // Compare against the post-update buffer address so a fill and a load
        // to the same word on one edge leave the buffer invalid.
        if (load_en && (load_addr == buf_addr_nx)) begin
            buf_valid_nx = 1'b0;
        end

        busy_nx = (state_nx == ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            lat_addr   <= '0;
            cnt        <= '0;
            buf_valid  <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
            read_data  <= '0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
        end else if (clk_en) begin
            state      <= state_nx;
            lat_addr   <= lat_addr_nx;
            cnt        <= cnt_nx;
            buf_valid  <= buf_valid_nx;
            buf_addr   <= buf_addr_nx;
            buf_data   <= buf_data_nx;
            read_data  <= read_data_nx;
            data_ready <= data_ready_nx;
            busy       <= busy_nx;
        end
    end

    // Program storage survives reset; only the load port writes it.
    always_ff @(posedge clk) begin
        if (clk_en && load_en) begin
            mem[load_addr] <= load_data;
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: a 2-wait-state and a 0-wait-state instance share
// stimulus; directed scenarios plus a randomized run against a transaction-level model.
module tb_imem_fetch_responder;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          clk_en    = 1'b1;
    logic          read_req  = 1'b0;
    logic [AW-1:0] read_addr = '0;
    logic          load_en   = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;

    logic [DW-1:0] rd2, rd0;
    logic          dr2, dr0, by2, by0;

    int n_cmp = 0;
    int n_bad = 0;

    imem_fetch_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(2)) dut2 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .read_req(read_req), .read_addr(read_addr),
        .read_data(rd2), .data_ready(dr2), .busy(by2),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    imem_fetch_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .read_req(read_req), .read_addr(read_addr),
        .read_data(rd0), .data_ready(dr0), .busy(by0),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    // Reference model, index 0 = 2 wait states, index 1 = 0 wait states.
    // A miss accepted on enabled edge e answers on enabled edge e+W.
    logic [DW-1:0] mm [2][64];
    bit            bv [2];
    logic [AW-1:0] ba [2];
    logic [DW-1:0] bd [2];
    bit            pend [2];
    logic [AW-1:0] paddr [2];
    int            ecnt [2];
    int            due [2];
    logic [DW-1:0] ex_rd [2];
    bit            ex_dr [2];
    bit            ex_busy [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            bv[k] = 0; pend[k] = 0; ex_rd[k] = '0; ex_dr[k] = 0; ex_busy[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int w;
            w = (k == 0) ? 2 : 0;
            ecnt[k] = ecnt[k] + 1;
            if (pend[k]) begin
                if (ecnt[k] == due[k]) begin
                    ex_rd[k] = mm[k][paddr[k]];
                    ex_dr[k] = 1;
                    bv[k] = 1; ba[k] = paddr[k]; bd[k] = ex_rd[k];
                    pend[k] = 0;
                end else begin
                    ex_dr[k] = 0;
                end
            end else if (read_req) begin
                if (bv[k] && ba[k] == read_addr) begin
                    ex_rd[k] = bd[k];
                    ex_dr[k] = 1;
                end else if (w == 0) begin
                    ex_rd[k] = mm[k][read_addr];
                    ex_dr[k] = 1;
                    bv[k] = 1; ba[k] = read_addr; bd[k] = ex_rd[k];
                end else begin
                    pend[k] = 1; due[k] = ecnt[k] + w; paddr[k] = read_addr;
                    ex_dr[k] = 0;
                end
            end else begin
                ex_dr[k] = 0;
            end
            ex_busy[k] = pend[k];
            if (load_en) begin
                if (bv[k] && ba[k] == load_addr) bv[k] = 0;
                mm[k][load_addr] = load_data;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            ecnt[k] = 0; due[k] = 0; ba[k] = '0; bd[k] = '0; paddr[k] = '0;
        end
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else if (clk_en) model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++; if (rd2 !== '0) begin n_bad++; $display("FAIL reset_rd: got %h want 0", rd2); end
        n_cmp++; if (dr2 !== 1'b0) begin n_bad++; $display("FAIL reset_dr: got %b want 0", dr2); end
        n_cmp++; if (by2 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", by2); end
        n_cmp++; if (dr0 !== 1'b0 || rd0 !== '0) begin n_bad++; $display("FAIL reset_w0: got dr=%b rd=%h want 0/0", dr0, rd0); end
        rst = 1'b1;
        pulses = 0;
        for (int a = 0; a < 64; a++) begin
            load_en = 1'b1; load_addr = AW'(a); load_data = $urandom;
            tick();
            if (dr2 !== 1'b0 || dr0 !== 1'b0) pulses++;
        end
        load_en = 1'b0;
        tick();
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL idle_no_pulse: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_miss_latency();
        load_en = 1'b1; load_addr = 6'd5; load_data = 32'h3C01_1234;
        tick();
        load_en = 1'b0;
        read_req = 1'b1; read_addr = 6'd5;
        tick();
        n_cmp++; if (by2 !== 1'b1 || dr2 !== 1'b0) begin n_bad++; $display("FAIL miss_c1: got busy=%b dr=%b want 1/0", by2, dr2); end
        n_cmp++; if (dr0 !== 1'b1 || rd0 !== 32'h3C01_1234) begin n_bad++; $display("FAIL w0_miss: got dr=%b rd=%h want 1/3c011234", dr0, rd0); end
        read_req = 1'b0;
        tick();
        n_cmp++; if (by2 !== 1'b1 || dr2 !== 1'b0) begin n_bad++; $display("FAIL miss_c2: got busy=%b dr=%b want 1/0", by2, dr2); end
        tick();
        n_cmp++; if (by2 !== 1'b0 || dr2 !== 1'b1 || rd2 !== 32'h3C01_1234) begin
            n_bad++; $display("FAIL miss_c3: got busy=%b dr=%b rd=%h want 0/1/3c011234", by2, dr2, rd2); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp6;
        exp6 = mm[0][6];
        read_req = 1'b1; read_addr = 6'd5;
        tick();
        n_cmp++; if (dr2 !== 1'b1 || rd2 !== 32'h3C01_1234 || by2 !== 1'b0) begin
            n_bad++; $display("FAIL hit_b2b: got dr=%b rd=%h busy=%b want 1/3c011234/0", dr2, rd2, by2); end
        read_addr = 6'd6;
        tick();
        n_cmp++; if (by2 !== 1'b1 || dr2 !== 1'b0) begin n_bad++; $display("FAIL miss6_c1: got busy=%b dr=%b want 1/0", by2, dr2); end
        n_cmp++; if (dr0 !== 1'b1 || rd0 !== exp6) begin n_bad++; $display("FAIL w0_b2b: got dr=%b rd=%h want 1/%h", dr0, rd0, exp6); end
        read_req = 1'b0;
        tick();
        tick();
        n_cmp++; if (dr2 !== 1'b1 || rd2 !== exp6) begin n_bad++; $display("FAIL miss6_c3: got dr=%b rd=%h want 1/%h", dr2, rd2, exp6); end
        tick();
        n_cmp++; if (dr2 !== 1'b0 || rd2 !== exp6) begin n_bad++; $display("FAIL resp_to_idle: got dr=%b rd=%h want 0/%h", dr2, rd2, exp6); end
    endtask

    task automatic test_load_invalidate();
        logic [DW-1:0] old7;
        read_req = 1'b1; read_addr = 6'd5;
        tick();
        read_req = 1'b0;
        tick(); tick();
        load_en = 1'b1; load_addr = 6'd5; load_data = 32'hDEAD_BEEF;
        tick();
        load_en = 1'b0;
        read_req = 1'b1; read_addr = 6'd5;
        tick();
        n_cmp++; if (by2 !== 1'b1) begin n_bad++; $display("FAIL inval_miss: got busy=%b want 1", by2); end
        n_cmp++; if (dr0 !== 1'b1 || rd0 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL w0_inval: got dr=%b rd=%h want 1/deadbeef", dr0, rd0); end
        read_req = 1'b0;
        tick(); tick();
        n_cmp++; if (dr2 !== 1'b1 || rd2 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL inval_data: got dr=%b rd=%h want 1/deadbeef", dr2, rd2); end
        old7 = mm[0][7];
        read_req = 1'b1; read_addr = 6'd7;
        tick();
        read_req = 1'b0;
        tick();
        load_en = 1'b1; load_addr = 6'd7; load_data = 32'h1234_5678;
        tick();
        load_en = 1'b0;
        n_cmp++; if (dr2 !== 1'b1 || rd2 !== old7) begin n_bad++; $display("FAIL same_edge_old: got dr=%b rd=%h want 1/%h", dr2, rd2, old7); end
        tick();
        read_req = 1'b1; read_addr = 6'd7;
        tick();
        n_cmp++; if (by2 !== 1'b1) begin n_bad++; $display("FAIL same_edge_inval: got busy=%b want 1", by2); end
        read_req = 1'b0;
        tick(); tick();
        n_cmp++; if (dr2 !== 1'b1 || rd2 !== 32'h1234_5678) begin n_bad++; $display("FAIL same_edge_new: got dr=%b rd=%h want 1/12345678", dr2, rd2); end
        tick();
    endtask

    task automatic test_stall();
        logic [DW-1:0] exp9;
        exp9 = mm[0][9];
        read_req = 1'b1; read_addr = 6'd9;
        tick();
        read_req = 1'b0;
        tick();
        n_cmp++; if (by2 !== 1'b1) begin n_bad++; $display("FAIL stall_pre: got busy=%b want 1", by2); end
        clk_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (by2 !== 1'b1 || dr2 !== 1'b0) begin
                n_bad++; $display("FAIL stall_hold%0d: got busy=%b dr=%b want 1/0", i, by2, dr2); end
        end
        clk_en = 1'b1;
        tick();
        n_cmp++; if (dr2 !== 1'b1 || rd2 !== exp9 || by2 !== 1'b0) begin
            n_bad++; $display("FAIL stall_done: got dr=%b rd=%h busy=%b want 1/%h/0", dr2, rd2, by2, exp9); end
        clk_en = 1'b0;
        tick(); tick();
        n_cmp++; if (dr2 !== 1'b1) begin n_bad++; $display("FAIL stall_stretch: got dr=%b want 1", dr2); end
        clk_en = 1'b1;
        tick();
        n_cmp++; if (dr2 !== 1'b0) begin n_bad++; $display("FAIL stall_release: got dr=%b want 0", dr2); end
    endtask

    task automatic test_abort();
        int pulses;
        read_req = 1'b1; read_addr = 6'd10;
        tick();
        read_req = 1'b0;
        n_cmp++; if (by2 !== 1'b1) begin n_bad++; $display("FAIL abort_pre: got busy=%b want 1", by2); end
        rst = 1'b0;
        #1;
        n_cmp++; if (by2 !== 1'b0 || dr2 !== 1'b0) begin n_bad++; $display("FAIL abort_async: got busy=%b dr=%b want 0/0", by2, dr2); end
        tick();
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dr2 !== 1'b0) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL abort_no_resp: got %0d pulses want 0", pulses); end
        read_req = 1'b1; read_addr = 6'd5;
        tick();
        read_req = 1'b0;
        n_cmp++; if (by2 !== 1'b1) begin n_bad++; $display("FAIL abort_buf_inval: got busy=%b want 1", by2); end
        tick(); tick();
        n_cmp++; if (dr2 !== 1'b1 || rd2 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL abort_mem_kept: got dr=%b rd=%h want 1/deadbeef", dr2, rd2); end
        tick();
    endtask

    task automatic test_w0_back_to_back();
        logic [AW-1:0] a;
        read_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = AW'($urandom_range(0, 63));
            read_addr = a;
            tick();
            n_cmp++; if (dr0 !== 1'b1 || rd0 !== mm[1][a] || by0 !== 1'b0) begin
                n_bad++; $display("FAIL w0_cont%0d: got dr=%b rd=%h busy=%b want 1/%h/0", i, dr0, rd0, by0, mm[1][a]); end
        end
        read_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            clk_en    = ($urandom_range(0, 9) != 0);
            read_req  = ($urandom_range(0, 2) != 0);
            read_addr = AW'($urandom_range(0, 7));
            load_en   = ($urandom_range(0, 6) == 0);
            load_addr = AW'($urandom_range(0, 7));
            load_data = $urandom;
            tick();
            n_cmp++; if (dr2 !== ex_dr[0] || by2 !== ex_busy[0] || rd2 !== ex_rd[0]) begin
                n_bad++; $display("FAIL rand_w2 @%0d: got dr=%b busy=%b rd=%h want %b/%b/%h",
                                  i, dr2, by2, rd2, ex_dr[0], ex_busy[0], ex_rd[0]); end
            n_cmp++; if (dr0 !== ex_dr[1] || by0 !== ex_busy[1] || rd0 !== ex_rd[1]) begin
                n_bad++; $display("FAIL rand_w0 @%0d: got dr=%b busy=%b rd=%h want %b/%b/%h",
                                  i, dr0, by0, rd0, ex_dr[1], ex_busy[1], ex_rd[1]); end
        end
        clk_en = 1'b1; read_req = 1'b0; load_en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_miss_latency();
        test_back_to_back();
        test_load_invalidate();
        test_stall();
        test_abort();
        test_w0_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Memory-side responder for the core's instruction-fetch read interface. It accepts word-address read requests, returns a 32-bit instruction word after a parameterised number of wait states, and raises a data_ready pulse. It holds a one-entry line buffer so a repeated fetch of the last address returns in one cycle. A load port lets the bench or boot logic write program words.

Parameters:
ADDR_W, 6, word-address width; storage depth is 2**ADDR_W words
DATA_W, 32, instruction word width
WAIT_STATES, 2, extra cycles on a buffer miss; legal range 0..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
clk_en  input  1  global advance enable; when low all state holds
read_req  input  1  fetch request, sampled when clk_en=1
read_addr  input  ADDR_W  fetch word address, sampled with read_req
read_data  output  DATA_W  returned instruction word, held until the next response
data_ready  output  1  one-cycle pulse: read_data is valid for the accepted request
busy  output  1  high while a miss is in wait states; requests are ignored
load_en  input  1  write strobe for program load, sampled when clk_en=1
load_addr  input  ADDR_W  load word address
load_data  input  DATA_W  load word

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE, read_data=0, data_ready=0, busy=0.
  - Buffer valid=0, wait counter=0.
  - Memory contents are not cleared.
  - A reset mid-wait aborts the fetch; no data_ready is produced.
- clk_en=0: FSM, counter, buffer, outputs and memory all hold. data_ready keeps its value, so the pulse stretches across stalled cycles.
- FSM states:
  - IDLE: no transaction.
  - WAIT: miss pending, counter running.
  - RESP: data_ready=1.
- Acceptance: a request is accepted on a clk_en edge when read_req=1 and state is IDLE or RESP (back-to-back fetches allowed). read_req in WAIT is ignored and not queued.
- Hit: accepted addr == buf_addr and buf_valid=1.
  - At the same edge: read_data <= buf_data, data_ready <= 1, go to RESP.
  - Latency 1 cycle.
- Miss, WAIT_STATES=0:
  - At the same edge: read_data <= mem[addr], data_ready <= 1, buf_addr/buf_data updated, buf_valid <= 1, go to RESP.
  - Latency 1 cycle.
- Miss, WAIT_STATES=W>0:
  - At the accept edge: latch addr, counter <= W, data_ready <= 0, busy <= 1, go to WAIT.
  - In WAIT, each clk_en edge decrements the counter.
  - At the edge where the counter is 1: read mem[latched addr], update buffer, data_ready <= 1, busy <= 0, go to RESP.
  - Latency 1+W cycles.
- RESP with no new request: next clk_en edge goes to IDLE and data_ready <= 0. read_data holds.
- Load (load_en=1 with clk_en=1): mem[load_addr] <= load_data at the edge. Loads are accepted in any state.
- Load and buffer: if load_addr == buf_addr, buf_valid <= 0 at the same edge.
  - A load landing on the same edge as a buffer update for the same address still leaves buf_valid=0.
- Load and reads, same edge: read-before-write.
  - A miss completing at the same edge as a load to the same address returns the old word, and the buffer ends invalid.
  - A load at any earlier edge of the wait is visible to the completing read.
- Load vs hit, same edge: if a hit is accepted at the same edge as a load to that address, the hit returns the old buffered word and the buffer is invalidated.
- Address wrap: none. Addresses are exactly ADDR_W bits and every value is legal.
- busy = (state == WAIT), registered.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release -> read_data=0, data_ready=0, busy=0; no data_ready pulse while read_req=0.
- Miss latency, W=2: load mem[5]=32'h3C01_1234, then request addr 5 -> busy high for 2 cycles, data_ready pulses in the 3rd cycle after accept with read_data=32'h3C01_1234.
- Buffer hit and back-to-back:
  - Request addr 5 again in the RESP cycle -> data_ready stays high the next cycle, read_data=32'h3C01_1234, busy stays 0.
  - Then request addr 6 -> miss timing of 3 cycles.
- Load invalidation:
  - After addr 5 is buffered, load mem[5]=32'hDEAD_BEEF and request addr 5 -> miss path (busy=1), returns 32'hDEAD_BEEF.
  - Same-edge load at completion of a miss to that address -> returns the old word; the next request to it misses.
- Stall and abort:
  - Drop clk_en for 4 cycles mid-WAIT -> counter and busy hold, and data_ready arrives 4 cycles later than normal.
  - Assert rst mid-WAIT -> busy=0 and no data_ready; after release, a new request to addr 5 misses (buffer invalid).
- W=0 build: every miss returns in 1 cycle and busy never asserts; read_req during RESP is accepted with continuous data_ready.
